// File: rtl/uart_event_rx_if.sv
// Record output port of the event-logger UART receiver: valid/ready handshake
// carrying one reassembled timestamp record.
interface uart_event_rx_if #(
   parameter int ID_W = 16,
   parameter int TS_W = 64
);
   logic            rec_valid;
   logic            rec_ready;
   logic [ID_W-1:0] rec_id;
   logic [TS_W-1:0] rec_start_ts;
   logic [TS_W-1:0] rec_end_ts;
   logic [TS_W-1:0] rec_delta;

   modport master (
      output rec_valid, rec_id, rec_start_ts, rec_end_ts, rec_delta,
      input  rec_ready
   );

   modport slave (
      input  rec_valid, rec_id, rec_start_ts, rec_end_ts, rec_delta,
      output rec_ready
   );
endinterface

// File: rtl/uart_event_rx.sv
// Event-logger UART receiver: 8N1 byte deserialiser plus header-hunting record
// reassembler with XOR checksum, inter-byte timeout and a held valid/ready output.
//
// byte FSM  | meaning
// B_IDLE    | line idle, waiting for a falling edge
// B_START   | half a bit in, confirming the start bit
// B_DATA    | sampling 8 data bits, LSB first
// B_STOP    | sampling the stop bit
// B_BRK     | stop bit was low, waiting for the line to return high
//
// record FSM | meaning
// R_HUNT     | discarding bytes until a 0xA5 header
// R_BODY     | collecting id/start/end/delta payload bytes
// R_CSUM     | next byte is the checksum
module uart_event_rx #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int BAUD    = 1_000_000,
   parameter int ID_W    = 16,
   parameter int TS_W    = 64,
   parameter int TO_BITS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx,
   uart_event_rx_if.master rec,
   output logic            err_frame,
   output logic            err_csum,
   output logic            err_overrun
);
   localparam int DIV       = CLK_HZ / BAUD;
   localparam int PAY_BYTES = ID_W/8 + 3*(TS_W/8);
   localparam int PAY_W     = 8*PAY_BYTES;
   localparam int TO_CLKS   = TO_BITS*DIV;
   localparam int BT_W      = $clog2(DIV);
   localparam int TO_W      = $clog2(TO_CLKS);
   localparam int BC_W      = $clog2(PAY_BYTES);

   localparam logic [BT_W-1:0] BIT_FULL = BT_W'(DIV-1);
   localparam logic [BT_W-1:0] BIT_HALF = BT_W'(DIV/2-1);
   localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TO_CLKS-1);
   localparam logic [BC_W-1:0] BC_LAST  = BC_W'(PAY_BYTES-1);
   localparam logic [7:0]      HDR      = 8'hA5;

   localparam logic [2:0] B_IDLE  = 3'd0;
   localparam logic [2:0] B_START = 3'd1;
   localparam logic [2:0] B_DATA  = 3'd2;
   localparam logic [2:0] B_STOP  = 3'd3;
   localparam logic [2:0] B_BRK   = 3'd4;

   localparam logic [1:0] R_HUNT = 2'd0;
   localparam logic [1:0] R_BODY = 2'd1;
   localparam logic [1:0] R_CSUM = 2'd2;

   logic            rx_meta, rx_s;
   logic [2:0]      b_st;
   logic [BT_W-1:0] bit_tmr;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            byte_stb;

   logic [1:0]       r_st;
   logic [BC_W-1:0]  byte_cnt;
   logic [7:0]       run_xor;
   logic [PAY_W-1:0] pay;
   logic [TO_W-1:0]  to_tmr;
   logic             timeout;
   logic             out_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // shreg is only shifted in B_DATA, so it still holds the byte when byte_stb fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_st      <= B_IDLE;
         bit_tmr   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         byte_stb  <= 1'b0;
         err_frame <= 1'b0;
      end else begin
         byte_stb  <= 1'b0;
         err_frame <= 1'b0;
         case (b_st)
            B_IDLE: begin
               if (!rx_s) begin
                  b_st    <= B_START;
                  bit_tmr <= BIT_HALF;
               end
            end
            B_START: begin
               if (bit_tmr == '0) begin
                  if (rx_s) begin
                     b_st <= B_IDLE;
                  end else begin
                     b_st    <= B_DATA;
                     bit_tmr <= BIT_FULL;
                     bit_cnt <= '0;
                  end
               end else begin
                  bit_tmr <= bit_tmr - 1'b1;
               end
            end
            B_DATA: begin
               if (bit_tmr == '0) begin
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_tmr <= BIT_FULL;
                  if (bit_cnt == 3'd7) b_st <= B_STOP;
                  else                 bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  bit_tmr <= bit_tmr - 1'b1;
               end
            end
            B_STOP: begin
               if (bit_tmr == '0) begin
                  if (rx_s) begin
                     byte_stb <= 1'b1;
                     b_st     <= B_IDLE;
                  end else begin
                     err_frame <= 1'b1;
                     b_st      <= B_BRK;
                  end
               end else begin
                  bit_tmr <= bit_tmr - 1'b1;
               end
            end
            B_BRK: begin
               if (rx_s) b_st <= B_IDLE;
            end
            default: b_st <= B_IDLE;
         endcase
      end
   end

   assign timeout  = !byte_stb && (to_tmr == '0);
   assign out_free = !rec.rec_valid || rec.rec_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st             <= R_HUNT;
         byte_cnt         <= '0;
         run_xor          <= '0;
         pay              <= '0;
         to_tmr           <= '0;
         err_csum         <= 1'b0;
         err_overrun      <= 1'b0;
         rec.rec_valid    <= 1'b0;
         rec.rec_id       <= '0;
         rec.rec_start_ts <= '0;
         rec.rec_end_ts   <= '0;
         rec.rec_delta    <= '0;
      end else begin
         err_csum    <= 1'b0;
         err_overrun <= 1'b0;
         if (rec.rec_valid && rec.rec_ready) rec.rec_valid <= 1'b0;

         if (byte_stb)            to_tmr <= TO_LOAD;
         else if (to_tmr != '0)   to_tmr <= to_tmr - 1'b1;

         case (r_st)
            R_HUNT: begin
               if (byte_stb && shreg == HDR) begin
                  r_st     <= R_BODY;
                  byte_cnt <= '0;
                  run_xor  <= '0;
               end
            end
            R_BODY: begin
               if (err_frame || timeout) begin
                  r_st <= R_HUNT;
               end else if (byte_stb) begin
                  pay     <= {pay[PAY_W-9:0], shreg};
                  run_xor <= run_xor ^ shreg;
                  if (byte_cnt == BC_LAST) r_st <= R_CSUM;
                  else                     byte_cnt <= byte_cnt + 1'b1;
               end
            end
            R_CSUM: begin
               if (err_frame || timeout) begin
                  r_st <= R_HUNT;
               end else if (byte_stb) begin
                  r_st <= R_HUNT;
                  if (shreg != run_xor) begin
                     err_csum <= 1'b1;
                  end else if (out_free) begin
                     rec.rec_valid    <= 1'b1;
                     rec.rec_id       <= pay[PAY_W-1 -: ID_W];
                     rec.rec_start_ts <= pay[3*TS_W-1 -: TS_W];
                     rec.rec_end_ts   <= pay[2*TS_W-1 -: TS_W];
                     rec.rec_delta    <= pay[TS_W-1:0];
                  end else begin
                     err_overrun <= 1'b1;
                  end
               end
            end
            default: r_st <= R_HUNT;
         endcase
      end
   end
endmodule
